// File: rtl/board_move_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : board_move_ctrl_pkg
//  Description : Shared constants for the board move controller: board size,
//                point encodings, FSM state encoding and small helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package board_move_ctrl_pkg;

    localparam int BOARD_DIM  = 16;
    localparam int COORD_W    = $clog2(BOARD_DIM);
    localparam int SWEEP_W    = 2 * COORD_W;
    localparam int MOVE_CNT_W = $clog2(BOARD_DIM * BOARD_DIM) + 1;
    localparam logic [MOVE_CNT_W-1:0] MAX_MOVES = MOVE_CNT_W'(BOARD_DIM * BOARD_DIM);

    // Board point encodings; the reserved code counts as an occupied point.
    localparam logic [1:0] PT_EMPTY = 2'b00;
    localparam logic [1:0] PT_P1    = 2'b01;
    localparam logic [1:0] PT_P2    = 2'b10;
    localparam logic [1:0] PT_RSVD  = 2'b11;

    // Controller state encoding.
    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_READ  = 3'd1;
    localparam logic [STATE_W-1:0] S_CHECK = 3'd2;
    localparam logic [STATE_W-1:0] S_WRITE = 3'd3;
    localparam logic [STATE_W-1:0] S_REJ   = 3'd4;
    localparam logic [STATE_W-1:0] S_CLEAR = 3'd5;

    // Point code written for a player (0 = player 1, 1 = player 2).
    function automatic logic [1:0] player_code(input logic player);
        return player ? PT_P2 : PT_P1;
    endfunction

    // One-hot grant/reject bit for a player.
    function automatic logic [1:0] player_mask(input logic player);
        return player ? 2'b10 : 2'b01;
    endfunction

    // Any non-empty code, including the reserved one, blocks a move.
    function automatic logic point_occupied(input logic [1:0] pt);
        return (pt == PT_P1) || (pt == PT_P2) || (pt == PT_RSVD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_sweep_counter.sv
`default_nettype none
// ============================================================================
//  Module      : board_sweep_counter
//  Description : 8-bit sweep counter walking every board point, y fastest.
//                Wraps to zero after the last point so the next sweep starts
//                at (0,0) without extra control.
//  Revision    : 1.0  initial release
// ============================================================================
module board_sweep_counter
    import board_move_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    output logic               o_done,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y
);

    logic [SWEEP_W-1:0] r_cnt;

    // Advance one point per enabled cycle; the top point wraps back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + SWEEP_W'(1);
        end
    end

    assign o_x    = r_cnt[SWEEP_W-1:COORD_W];
    assign o_y    = r_cnt[COORD_W-1:0];
    assign o_done = i_en && (r_cnt == {SWEEP_W{1'b1}});

endmodule
`default_nettype wire

// File: rtl/board_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : board_move_ctrl
//  Description : Two-player board move arbiter. Validates a move against the
//                board (read, check empty, write), enforces turn order and a
//                move limit, and sweeps the whole board clear on request.
//  Revision    : 1.0  initial release
// ============================================================================
module board_move_ctrl
    import board_move_ctrl_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  p1_req,
    input  logic [COORD_W-1:0]    p1_x,
    input  logic [COORD_W-1:0]    p1_y,
    input  logic                  p2_req,
    input  logic [COORD_W-1:0]    p2_x,
    input  logic [COORD_W-1:0]    p2_y,
    input  logic                  clear_req,
    output logic [COORD_W-1:0]    rd_x,
    output logic [COORD_W-1:0]    rd_y,
    input  logic [1:0]            rd_data,
    output logic                  wr_en,
    output logic [COORD_W-1:0]    wr_x,
    output logic [COORD_W-1:0]    wr_y,
    output logic [1:0]            wr_data,
    output logic [1:0]            grant,
    output logic [1:0]            reject,
    output logic                  turn,
    output logic                  busy,
    output logic [MOVE_CNT_W-1:0] move_count
);

    logic [STATE_W-1:0]    r_state;
    logic [STATE_W-1:0]    w_next_state;
    logic                  r_player;      // requester being processed
    logic [COORD_W-1:0]    r_x;
    logic [COORD_W-1:0]    r_y;
    logic                  r_turn;
    logic [MOVE_CNT_W-1:0] r_count;
    logic [1:0]            r_idle_rej;    // rejects decided in IDLE, shown next cycle

    logic                  w_accept;
    logic [1:0]            w_idle_rej;
    logic [1:0]            w_req;
    logic                  w_turn_req;
    logic                  w_full;
    logic                  w_sweep_en;
    logic                  w_sweep_done;
    logic [COORD_W-1:0]    w_sweep_x;
    logic [COORD_W-1:0]    w_sweep_y;

    assign w_req      = {p2_req, p1_req};
    assign w_turn_req = r_turn ? p2_req : p1_req;
    assign w_full     = (r_count == MAX_MOVES);
    assign w_sweep_en = (r_state == S_CLEAR);

    board_sweep_counter u_sweep (
        .clk    (clock),
        .rst    (reset),
        .i_en   (w_sweep_en),
        .o_done (w_sweep_done),
        .o_x    (w_sweep_x),
        .o_y    (w_sweep_y)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the IDLE accept/reject decision.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_idle_rej   = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (clear_req) begin
                    w_next_state = S_CLEAR;
                end else if (w_full) begin
                    w_idle_rej = w_req;
                end else begin
                    // Only the turn player may start a move; the other is bounced.
                    w_idle_rej = w_req & ~player_mask(r_turn);
                    if (w_turn_req) begin
                        w_accept     = 1'b1;
                        w_next_state = S_READ;
                    end
                end
            end
            S_READ:  w_next_state = S_CHECK;
            S_CHECK: w_next_state = point_occupied(rd_data) ? S_REJ : S_WRITE;
            S_WRITE: w_next_state = S_IDLE;
            S_REJ:   w_next_state = S_IDLE;
            S_CLEAR: begin
                if (w_sweep_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Requester latch, turn/move bookkeeping and registered IDLE rejects.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_player   <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_turn     <= 1'b0;
            r_count    <= '0;
            r_idle_rej <= 2'b00;
        end else begin
            r_idle_rej <= w_idle_rej;
            if (w_accept) begin
                r_player <= r_turn;
                r_x      <= r_turn ? p2_x : p1_x;
                r_y      <= r_turn ? p2_y : p1_y;
            end
            if (r_state == S_WRITE) begin
                r_turn  <= ~r_turn;
                r_count <= r_count + MOVE_CNT_W'(1);
            end else if (w_sweep_done) begin
                r_turn  <= 1'b0;
                r_count <= '0;
            end
        end
    end

    assign rd_x       = r_x;
    assign rd_y       = r_y;
    assign wr_en      = (r_state == S_WRITE) || (r_state == S_CLEAR);
    assign wr_x       = (r_state == S_CLEAR) ? w_sweep_x : r_x;
    assign wr_y       = (r_state == S_CLEAR) ? w_sweep_y : r_y;
    assign wr_data    = (r_state == S_WRITE) ? player_code(r_player) : PT_EMPTY;
    assign grant      = (r_state == S_WRITE) ? player_mask(r_player) : 2'b00;
    assign reject     = r_idle_rej | ((r_state == S_REJ) ? player_mask(r_player) : 2'b00);
    assign turn       = r_turn;
    assign busy       = (r_state != S_IDLE);
    assign move_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_board_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_move_ctrl
//  Description : Self-checking bench for board_move_ctrl: directed scenarios
//                plus randomized move traffic checked against a
//                transaction-level game model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_board_move_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       p1_req = 1'b0, p2_req = 1'b0, clear_req = 1'b0;
    logic [3:0] p1_x = '0, p1_y = '0, p2_x = '0, p2_y = '0;
    logic [3:0] rd_x, rd_y, wr_x, wr_y;
    logic [1:0] rd_data = 2'b00;
    logic       wr_en, turn, busy;
    logic [1:0] wr_data, grant, reject;
    logic [8:0] move_count;

    int n_checks = 0;
    int n_errors = 0;

    // Game model: board contents, whose turn, accepted-move count.
    int ref_board [16][16];
    int ref_turn  = 0;
    int ref_count = 0;

    // Board storage seen by the controller: registered read, write on strobe.
    logic [1:0] r_board [16][16] = '{default: '{default: 2'b00}};

    always #5 clock = ~clock;

    board_move_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .p1_req     (p1_req),
        .p1_x       (p1_x),
        .p1_y       (p1_y),
        .p2_req     (p2_req),
        .p2_x       (p2_x),
        .p2_y       (p2_y),
        .clear_req  (clear_req),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_data    (wr_data),
        .grant      (grant),
        .reject     (reject),
        .turn       (turn),
        .busy       (busy),
        .move_count (move_count)
    );

    always @(posedge clock) begin
        if (wr_en) r_board[wr_x][wr_y] <= wr_data;
        rd_data <= r_board[rd_x][rd_y];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One IDLE-sampled request pattern, followed until the controller is idle.
    task automatic do_txn(input logic a1, input logic a2,
                          input logic [3:0] x1, input logic [3:0] y1,
                          input logic [3:0] x2, input logic [3:0] y2,
                          input logic clr);
        int e_rej_early = 0, e_rej_late = 0, e_grant = 0, e_writes = 0;
        int e_wx = 0, e_wy = 0, e_wd = 0, e_cyc = 1;
        int e_turn = ref_turn, e_count = ref_count;
        int o_rej_early = 0, o_rej_late = 0, o_grant = 0, o_writes = 0;
        int o_wx = 0, o_wy = 0, o_wd = 0, grant_cyc = 0, bad_order = 0, cyc = 1;
        int tp, tx, ty;
        logic treq, oreq;

        if (clr) begin
            e_writes = 256; e_cyc = 257; e_turn = 0; e_count = 0;
            foreach (ref_board[i, j]) ref_board[i][j] = 0;
        end else if (ref_count == 256) begin
            e_rej_early = int'(a1) + 2 * int'(a2);
        end else begin
            tp   = ref_turn;
            treq = (tp == 1) ? a2 : a1;
            oreq = (tp == 1) ? a1 : a2;
            if (oreq) e_rej_early = (tp == 1) ? 1 : 2;
            if (treq) begin
                e_cyc = 4;
                tx = (tp == 1) ? int'(x2) : int'(x1);
                ty = (tp == 1) ? int'(y2) : int'(y1);
                if (ref_board[tx][ty] == 0) begin
                    e_grant = tp + 1; e_writes = 1;
                    e_wx = tx; e_wy = ty; e_wd = tp + 1;
                    ref_board[tx][ty] = tp + 1;
                    e_turn = 1 - tp; e_count = ref_count + 1;
                end else begin
                    e_rej_late = tp + 1;
                end
            end
        end

        @(negedge clock);
        p1_req = a1; p1_x = x1; p1_y = y1;
        p2_req = a2; p2_x = x2; p2_y = y2;
        clear_req = clr;
        @(negedge clock);
        forever begin
            if (cyc == 1) o_rej_early = int'(reject);
            else          o_rej_late |= int'(reject);
            o_grant |= int'(grant);
            if (grant != 2'b00) grant_cyc = cyc;
            if (wr_en) begin
                if (clr && (({wr_x, wr_y} != o_writes[7:0]) || (wr_data != 2'b00))) bad_order++;
                o_wx = int'(wr_x); o_wy = int'(wr_y); o_wd = int'(wr_data);
                o_writes++;
            end
            if (!busy || cyc >= 300) begin
                p1_req = 1'b0; p2_req = 1'b0; clear_req = 1'b0;
                break;
            end
            // Traffic while busy must be ignored by the controller.
            p1_req = 1'($urandom); p2_req = 1'($urandom); clear_req = 1'($urandom);
            p1_x = 4'($urandom); p1_y = 4'($urandom);
            p2_x = 4'($urandom); p2_y = 4'($urandom);
            @(negedge clock);
            cyc++;
        end

        chk("txn_cycles", cyc, e_cyc);
        chk("reject_idle", o_rej_early, e_rej_early);
        chk("reject_rej", o_rej_late, e_rej_late);
        chk("grant", o_grant, e_grant);
        chk("write_count", o_writes, e_writes);
        if (e_grant != 0) chk("grant_cycle", grant_cyc, 3);
        if (e_writes == 1) begin
            chk("wr_x", o_wx, e_wx);
            chk("wr_y", o_wy, e_wy);
            chk("wr_data", o_wd, e_wd);
        end
        if (clr) chk("clear_order", bad_order, 0);
        chk("turn", int'(turn), e_turn);
        chk("move_count", int'(move_count), e_count);
        ref_turn  = e_turn;
        ref_count = e_count;
    endtask

    initial begin
        foreach (ref_board[i, j]) ref_board[i][j] = 0;

        repeat (3) @(negedge clock);
        chk("reset_outputs", {rd_x, rd_y, wr_en, wr_x, wr_y, wr_data, grant, reject, turn, busy, move_count}, 0);
        reset = 1'b0;

        // Directed: accepted move, occupied target, simultaneous requests, clear.
        do_txn(1'b1, 1'b0, 4'd3, 4'd5, 4'd0, 4'd0, 1'b0);
        do_txn(1'b0, 1'b1, 4'd0, 4'd0, 4'd3, 4'd5, 1'b0);
        do_txn(1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 4'd7, 1'b0);
        do_txn(1'b1, 1'b1, 4'd4, 4'd4, 4'd9, 4'd9, 1'b0);
        do_txn(1'b1, 1'b0, 4'd2, 4'd2, 4'd0, 4'd0, 1'b1);

        // Randomized traffic; small coordinate range forces collisions.
        repeat (150) begin
            do_txn(1'($urandom), 1'($urandom),
                   4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   ($urandom_range(0, 29) == 0));
        end

        // Fill every point with alternating moves, then hit the move limit.
        do_txn(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        for (int i = 0; i < 256; i++) begin
            do_txn(i[0] == 1'b0, i[0] == 1'b1, 4'(i >> 4), 4'(i), 4'(i >> 4), 4'(i), 1'b0);
        end
        do_txn(1'b1, 1'b0, 4'd1, 4'd1, 4'd0, 4'd0, 1'b0);
        do_txn(1'b1, 1'b1, 4'd1, 4'd1, 4'd2, 4'd2, 1'b0);
        do_txn(1'b0, 1'b1, 4'd0, 4'd0, 4'd2, 4'd2, 1'b0);

        // Reset on the 100th clear cycle aborts the sweep.
        @(negedge clock);
        clear_req = 1'b1;
        @(negedge clock);
        clear_req = 1'b0;
        repeat (99) @(negedge clock);
        chk("abort_pre_wr_en", wr_en, 1);
        chk("abort_pre_addr", {wr_x, wr_y}, 99);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_wr_en", wr_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_outputs", {rd_x, rd_y, wr_en, wr_x, wr_y, wr_data, grant, reject, turn, busy, move_count}, 0);
        reset = 1'b0;
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/board_move_ctrl.md
BOARD_MOVE_CTRL -- requirements
Module: board_move_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; these ports SHALL be named clock and reset.
REQ-002 Port clock, input, 1 bit: rising-edge clock for all state.
REQ-003 Port reset, input, 1 bit: synchronous active-high reset.
REQ-004 Port p1_req, input, 1 bit: player-1 move request (level).
REQ-005 Port p1_x / p1_y, input, 4 bits each: player-1 target coordinates.
REQ-006 Port p2_req, input, 1 bit: player-2 move request (level).
REQ-007 Port p2_x / p2_y, input, 4 bits each: player-2 target coordinates.
REQ-008 Port clear_req, input, 1 bit: request to wipe the whole 16x16 board.
REQ-009 Port rd_x / rd_y, output, 4 bits each: board read address.
REQ-010 Port rd_data, input, 2 bits: board point at rd_x/rd_y, valid one cycle after the address changes.
REQ-011 Port wr_en, output, 1 bit: board write strobe.
REQ-012 Port wr_x / wr_y / wr_data, output, 4/4/2 bits: write address and point value.
REQ-013 Port grant, output, 2 bits: one-cycle pulse; bit0 = player 1 move accepted, bit1 = player 2 move accepted.
REQ-014 Port reject, output, 2 bits: one-cycle pulse per player, with the same bit mapping as grant.
REQ-015 Port turn, output, 1 bit: 0 = player 1 to move, 1 = player 2 to move.
REQ-016 Port busy, output, 1 bit: high in every state except IDLE.
REQ-017 Port move_count, output, 9 bits: number of accepted moves, 0..256.

Function
REQ-018 Point encoding SHALL be 00 empty, 01 player 1, 10 player 2, 11 reserved (treated as occupied).
REQ-019 The FSM SHALL have states IDLE, READ, CHECK, WRITE, REJ and CLEAR.
REQ-020 In IDLE, clear_req SHALL have priority over both move requests and SHALL cause a transition to CLEAR.
REQ-021 In IDLE, a request from the current-turn player with move_count < 256 SHALL latch its x/y onto rd_x/rd_y and wr_x/wr_y, and the FSM SHALL go to READ.
REQ-022 In IDLE, a request from the non-turn player, or any request when move_count = 256, SHALL pulse that player's reject bit in the next cycle; the FSM SHALL stay in IDLE.
REQ-023 When both players request in the same IDLE cycle, the turn player SHALL be processed and the other player rejected per REQ-022.
REQ-024 The FSM SHALL go READ -> CHECK unconditionally; CHECK SHALL sample rd_data.
REQ-025 From CHECK, rd_data = 00 SHALL lead to WRITE; any other value SHALL lead to REJ.
REQ-026 In WRITE, for one cycle: wr_en = 1, wr_data = player code, that player's grant bit pulses, turn toggles, move_count increments; then the FSM returns to IDLE.
REQ-027 In REJ, for one cycle: the requester's reject bit pulses, turn and move_count are unchanged; then the FSM returns to IDLE.
REQ-028 Accept latency SHALL be 4 cycles from the sampling edge in IDLE to return to IDLE; the grant pulse SHALL occur in the 3rd cycle after sampling.
REQ-029 CLEAR SHALL write 00 to all 256 points over 256 consecutive cycles with wr_en = 1, y incrementing fastest, and x wrapping 15 -> 0 to end the sweep.
REQ-030 On CLEAR completion: move_count = 0, turn = 0, FSM -> IDLE.
REQ-031 Requests and clear_req SHALL be ignored outside IDLE; no reject SHALL be issued for them.
REQ-032 Requester identity and coordinates SHALL be held stable from the IDLE sample until the FSM returns to IDLE.

Reset
REQ-033 On reset, all outputs SHALL be 0 (wr_en, grant, reject, turn, busy, move_count, and all address/data outputs) and the FSM SHALL be in IDLE.
REQ-034 Reset asserted mid-CLEAR or mid-move SHALL abort the operation immediately, with no further wr_en; board contents are left to the board's own reset.

Structure
REQ-035 A shared package SHALL hold BOARD_DIM = 16, the point encodings, and the FSM state encoding.
REQ-036 The 8-bit clear sweep counter SHALL be a sub-module named board_sweep_counter, with enable, done and x/y outputs.

Verification
REQ-037 Test 1: after reset, p1_req with (3,5) on an empty board -> grant = 01 on cycle 3, wr_en with (3,5,01), turn = 1, move_count = 1.
REQ-038 Test 2: p2_req targeting cell (3,5) already holding 01 -> reject = 10 in REJ, no wr_en, turn stays 1.
REQ-039 Test 3: p1_req and p2_req together while turn = 0 -> p2 rejected the next cycle, p1 processed and granted.
REQ-040 Test 4: clear_req and p1_req together -> exactly 256 writes of 00 in order (0,0)..(15,15), then move_count = 0, turn = 0, and no grant.
REQ-041 Test 5: move_count forced to 256 by 256 alternating valid moves, then any request -> reject pulse, FSM stays IDLE.
REQ-042 Test 6: reset asserted on the 100th CLEAR cycle -> wr_en = 0 and busy = 0 next cycle, and all outputs 0.
